dna_seq_writer: RTL

- Loads a DNA sequence into the shared 16-bit word memory that the pattern-search FSM later scans.
- Accepts a stream of 2-bit nucleotides over a valid/ready handshake.
- Packs 8 nucleotides per word, MSB-first, and writes the words to consecutive addresses starting at a latched base address.
- On completion it reports the nucleotide count, which is fed directly to the searcher's dna_start/dna_length inputs.

---
 rtl/dna_pkg.sv | 6 +
 rtl/dna_seq_writer_if.sv | 9 +
 rtl/dna_packer.sv | 29 ++
 rtl/dna_seq_writer.sv | 68 ++++++
 4 files changed

// File: rtl/dna_pkg.sv
// dna_pkg: nucleotide encoding, packing geometry and writer states shared by writer and searcher
package dna_pkg;
  typedef enum logic [1:0] {A = 2'b00, C = 2'b01, G = 2'b10, T = 2'b11} nuc_t;
  localparam int NUCS_PER_WORD = 8;
  typedef enum logic [1:0] {IDLE, RECV, DONE} writer_state_t;
endpackage

// File: rtl/dna_seq_writer_if.sv
// dna_seq_writer_if: nucleotide stream in (nuc_in/nuc_valid/nuc_last/nuc_ready) and memory write port out (mem_addr/mem_data/mem_we)
interface dna_seq_writer_if import dna_pkg::*; #(parameter int ADDR_W = 16);
  nuc_t nuc_in;
  logic nuc_valid, nuc_last, nuc_ready, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0] mem_data;
  modport master (output nuc_in, nuc_valid, nuc_last, input nuc_ready, mem_addr, mem_data, mem_we);
  modport slave (input nuc_in, nuc_valid, nuc_last, output nuc_ready, mem_addr, mem_data, mem_we);
endinterface

// File: rtl/dna_packer.sv
// dna_packer: packs nucleotides MSB-first into a 16-bit word
// ports: clock, reset_N, clear (wins over push), push + nuc; word = buffer with the pushed nucleotide merged in, full = last slot, empty = no slot used
module dna_packer import dna_pkg::*; (
  input  logic clock,
  input  logic reset_N,
  input  logic clear,
  input  logic push,
  input  nuc_t nuc,
  output logic [15:0] word,
  output logic full,
  output logic empty
);
  logic [2:0] slot;
  logic [15:0] pack_q;
  assign word = push ? pack_q | (16'(nuc) << (4'd14 - {slot, 1'b0})) : pack_q;
  assign full = slot == 3'(NUCS_PER_WORD - 1);
  assign empty = slot == 3'd0;
  always_ff @(posedge clock or negedge reset_N)
    if (!reset_N) begin
      slot <= '0;
      pack_q <= '0;
    end else if (clear) begin
      slot <= '0;
      pack_q <= '0;
    end else if (push) begin
      slot <= slot + 3'd1;
      pack_q <= word;
    end
endmodule

// File: rtl/dna_seq_writer.sv
// dna_seq_writer: streams 2-bit nucleotides into consecutive 16-bit memory words from a latched base
// ports: clock, reset_N, start + base_addr begin a load, bus carries the nucleotide stream and memory write port,
// dna_length/done/error report the load outcome
module dna_seq_writer import dna_pkg::*; #(
  parameter int MAX_LEN = 1024,
  parameter int ADDR_W = 16
) (
  input  logic clock,
  input  logic reset_N,
  input  logic start,
  input  logic [ADDR_W-1:0] base_addr,
  dna_seq_writer_if.slave bus,
  output logic [15:0] dna_length,
  output logic done,
  output logic error
);
  writer_state_t state;
  logic [ADDR_W-1:0] base, word_idx;
  logic [15:0] word;
  logic full, empty, take, ovf, push, flush, wr, go;
  assign bus.nuc_ready = state == RECV;
  assign take = bus.nuc_valid && state == RECV;
  assign ovf = take && dna_length == 16'(MAX_LEN);
  assign push = take && !ovf;
  assign flush = push && (full || bus.nuc_last);
  // an overflow flushes whatever partial word is still buffered
  assign wr = flush || (ovf && !empty);
  assign go = start && state != RECV;
  dna_packer u_packer (
    .clock(clock), .reset_N(reset_N), .clear(go || flush), .push(push),
    .nuc(bus.nuc_in), .word(word), .full(full), .empty(empty)
  );
  always_ff @(posedge clock or negedge reset_N)
    if (!reset_N) begin
      state <= IDLE;
      base <= '0;
      word_idx <= '0;
      dna_length <= '0;
      done <= 1'b0;
      error <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_data <= '0;
    end else begin
      bus.mem_we <= wr;
      if (wr) begin
        bus.mem_addr <= base + word_idx;
        bus.mem_data <= word;
      end
      if (flush) word_idx <= word_idx + ADDR_W'(1);
      if (push) dna_length <= dna_length + 16'd1;
      if (go) begin
        state <= RECV;
        base <= base_addr;
        word_idx <= '0;
        dna_length <= '0;
        done <= 1'b0;
        error <= 1'b0;
      end else if (ovf) begin
        state <= DONE;
        done <= 1'b1;
        error <= 1'b1;
      end else if (push && bus.nuc_last) begin
        state <= DONE;
        done <= 1'b1;
      end
    end
endmodule
